// File: rtl/dj8_bus_responder.sv
// Off-chip responder for the DJ8 multiplexed pin bus: RAM window, small I/O page
// at 0x7F00, free-running tick counter and a sticky protocol-error flag.
module dj8_bus_responder #(
  parameter int ADDR_BITS = 8,
  parameter int TICK_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_hi,
  input  logic [7:0] bus_lo,
  output logic [7:0] data_to_cpu,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       wr_strobe,
  output logic       proto_err
);

  localparam int RAM_WORDS = 1 << ADDR_BITS;
  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [14:0] A_GPIO_OUT = 15'h7F00;
  localparam logic [14:0] A_GPIO_IN  = 15'h7F01;
  localparam logic [14:0] A_TICK_LO  = 15'h7F02;
  localparam logic [14:0] A_TICK_HI  = 15'h7F03;
  localparam logic [14:0] A_ERR      = 15'h7F04;

  logic              we;
  logic [14:0]       rd_addr;
  logic [14:0]       wr_addr;
  logic [7:0]        addr_lo_q;
  logic              prev_we;
  logic [15:0]       tick;
  logic [PW-1:0]     prescaler;
  logic [7:0]        hi_latch;
  logic              ram_we;
  logic              err_set;
  logic              err_clr;
  logic [ADDR_BITS-1:0] ram_rd_idx;
  logic [ADDR_BITS-1:0] ram_wr_idx;
  logic [7:0]        ram [RAM_WORDS];

  assign we         = bus_hi[7];
  assign rd_addr    = {bus_hi[6:0], bus_lo};
  // A write cycle reuses the low address byte captured in the preceding address phase.
  assign wr_addr    = {bus_hi[6:0], addr_lo_q};
  assign ram_rd_idx = rd_addr[ADDR_BITS-1:0];
  assign ram_wr_idx = wr_addr[ADDR_BITS-1:0];
  assign ram_we     = we && !wr_addr[14];
  assign err_set    = we && prev_we;
  assign err_clr    = we && (wr_addr == A_ERR);

  // RAM contents survive reset; only the write at a reset edge is suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset) begin
      if (ram_we) ram[ram_wr_idx] <= bus_lo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_lo_q <= 8'h00;
      prev_we   <= 1'b0;
      gpio_out  <= 8'h00;
      tick      <= 16'h0000;
      prescaler <= '0;
      hi_latch  <= 8'h00;
      wr_strobe <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      prev_we   <= we;
      wr_strobe <= we;

      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        tick      <= tick + 16'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end

      if (!we) begin
        addr_lo_q <= bus_lo;
        if (rd_addr == A_TICK_LO) hi_latch <= tick[15:8];
      end else if (wr_addr == A_GPIO_OUT) begin
        gpio_out <= bus_lo;
      end

      // A missing address phase outranks a clear landing in the same cycle.
      if (err_set)      proto_err <= 1'b1;
      else if (err_clr) proto_err <= 1'b0;
    end
  end

  always_comb begin
    data_to_cpu = 8'hFF;
    if (!we) begin
      if (!rd_addr[14]) begin
        data_to_cpu = ram[ram_rd_idx];
      end else begin
        case (rd_addr)
          A_GPIO_OUT: data_to_cpu = gpio_out;
          A_GPIO_IN:  data_to_cpu = gpio_in;
          A_TICK_LO:  data_to_cpu = tick[7:0];
          A_TICK_HI:  data_to_cpu = hi_latch;
          A_ERR:      data_to_cpu = {7'b0, proto_err};
          default:    data_to_cpu = 8'hFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dj8_bus_responder.sv
// Directed plus randomized bench for dj8_bus_responder against a behavioural
// model of the bus rules (tick derived from elapsed cycles since reset).
module tb_dj8_bus_responder;

  localparam int AB   = 8;
  localparam int TD   = 4;
  localparam int RAMW = 1 << AB;

  logic       clk;
  logic       reset;
  logic [7:0] bus_hi;
  logic [7:0] bus_lo;
  logic [7:0] data_to_cpu;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       wr_strobe;
  logic       proto_err;

  dj8_bus_responder #(.ADDR_BITS(AB), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .bus_hi(bus_hi), .bus_lo(bus_lo),
    .data_to_cpu(data_to_cpu), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .wr_strobe(wr_strobe), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_ram [RAMW];
  logic [7:0] m_gpio;
  logic [7:0] m_addr_lo;
  logic [7:0] m_hi_latch;
  logic       m_prev_we;
  logic       m_perr;
  logic       m_strobe;
  int         m_edges;

  function automatic logic [15:0] m_tick();
    return 16'((m_edges / TD) % 65536);
  endfunction

  function automatic void model_reset();
    m_gpio = 8'h00; m_addr_lo = 8'h00; m_hi_latch = 8'h00;
    m_prev_we = 1'b0; m_perr = 1'b0; m_strobe = 1'b0; m_edges = 0;
  endfunction

  function automatic logic [7:0] model_read(logic [7:0] hi, logic [7:0] lo);
    logic [14:0] a;
    logic [15:0] t;
    a = {hi[6:0], lo};
    t = m_tick();
    if (hi[7]) return 8'hFF;
    if (a < 15'h4000) return m_ram[int'(a) % RAMW];
    case (a)
      15'h7F00: return m_gpio;
      15'h7F01: return gpio_in;
      15'h7F02: return t[7:0];
      15'h7F03: return m_hi_latch;
      15'h7F04: return {7'b0, m_perr};
      default:  return 8'hFF;
    endcase
  endfunction

  function automatic void model_edge(logic [7:0] hi, logic [7:0] lo);
    logic [14:0] a;
    logic [14:0] wa;
    logic [15:0] t;
    a  = {hi[6:0], lo};
    wa = {hi[6:0], m_addr_lo};
    t  = m_tick();
    if (!hi[7]) begin
      if (a == 15'h7F02) m_hi_latch = t[15:8];
      m_addr_lo = lo;
    end else begin
      if (wa < 15'h4000) m_ram[int'(wa) % RAMW] = lo;
      if (wa == 15'h7F00) m_gpio = lo;
      if (wa == 15'h7F04) m_perr = 1'b0;
      if (m_prev_we) m_perr = 1'b1;
    end
    m_strobe  = hi[7];
    m_prev_we = hi[7];
    m_edges++;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives the bus, checks, lets one rising edge happen, returns at the next negedge.
  task automatic step(input logic [7:0] hi, input logic [7:0] lo, output logic [7:0] rd);
    bus_hi = hi;
    bus_lo = lo;
    #1;
    rd = data_to_cpu;
    chk("data_to_cpu", data_to_cpu, model_read(hi, lo));
    chk("gpio_out", gpio_out, m_gpio);
    chk("wr_strobe", {7'b0, wr_strobe}, {7'b0, m_strobe});
    chk("proto_err", {7'b0, proto_err}, {7'b0, m_perr});
    @(posedge clk);
    if (!reset) model_edge(hi, lo);
    @(negedge clk);
  endtask

  logic [7:0] rd;
  logic [6:0] h7;
  logic [7:0] l8;
  logic       wb;

  initial begin
    reset   = 1'b1;
    bus_hi  = 8'h7F;
    bus_lo  = 8'h05;
    gpio_in = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_gpio_out", gpio_out, 8'h00);
    chk("rst_wr_strobe", {7'b0, wr_strobe}, 8'h00);
    chk("rst_proto_err", {7'b0, proto_err}, 8'h00);
    reset = 1'b0;

    // tick: 1032 edges at TICK_DIV=4 -> 0x0102
    for (int i = 0; i < 1032; i++) step(8'h7F, 8'h05, rd);
    step(8'h7F, 8'h02, rd);
    chk("tick_live_lo", rd, 8'h02);
    for (int i = 0; i < 9; i++) step(8'h7F, 8'h05, rd);
    step(8'h7F, 8'h03, rd);
    chk("tick_hi_latch", rd, 8'h01);

    // preload the whole RAM so every later read has a defined expectation
    for (int i = 0; i < RAMW; i++) begin
      step(8'h00, 8'(i), rd);
      step(8'h80, 8'($urandom), rd);
    end

    // RAM write/read and mirror
    step(8'h00, 8'h34, rd);
    step(8'h80, 8'hA5, rd);
    chk("ram_wr_strobe", {7'b0, wr_strobe}, 8'h01);
    step(8'h00, 8'h34, rd);
    chk("ram_read", rd, 8'hA5);
    chk("strobe_drop", {7'b0, wr_strobe}, 8'h00);
    step(8'h12, 8'h34, rd);
    chk("ram_mirror", rd, 8'hA5);

    // GPIO
    step(8'h00, 8'h00, rd);
    step(8'hFF, 8'h5A, rd);
    chk("gpio_out_write", gpio_out, 8'h5A);
    step(8'h7F, 8'h00, rd);
    chk("gpio_out_read", rd, 8'h5A);
    gpio_in = 8'hC3;
    step(8'h7F, 8'h01, rd);
    chk("gpio_in_read", rd, 8'hC3);

    // protocol error, stale address, clear, set-wins
    step(8'h00, 8'h10, rd);
    step(8'h80, 8'h11, rd);
    step(8'h80, 8'h22, rd);
    chk("perr_set", {7'b0, proto_err}, 8'h01);
    step(8'h00, 8'h10, rd);
    chk("perr_stale_addr", rd, 8'h22);
    step(8'h00, 8'h04, rd);
    step(8'hFF, 8'h00, rd);
    chk("perr_clear", {7'b0, proto_err}, 8'h00);
    step(8'h00, 8'h04, rd);
    step(8'h80, 8'h66, rd);
    step(8'hFF, 8'h00, rd);
    chk("perr_set_wins", {7'b0, proto_err}, 8'h01);
    step(8'h7F, 8'h04, rd);
    chk("perr_read", rd, 8'h01);

    // unmapped reads and ignored write
    step(8'h40, 8'h00, rd);
    chk("unmapped_4000", rd, 8'hFF);
    step(8'h7F, 8'h05, rd);
    chk("unmapped_7f05", rd, 8'hFF);
    step(8'h40, 8'h00, rd);
    step(8'hC0, 8'h99, rd);
    chk("ignored_wr_strobe", {7'b0, wr_strobe}, 8'h01);
    step(8'h00, 8'h00, rd);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      gpio_in = 8'($urandom);
      case ($urandom_range(0, 2))
        0: begin h7 = 7'h7F; l8 = 8'($urandom_range(0, 6)); end
        1: begin h7 = 7'($urandom_range(0, 63)); l8 = 8'($urandom); end
        default: begin h7 = 7'h40 | 7'($urandom_range(0, 63)); l8 = 8'($urandom); end
      endcase
      wb = ($urandom_range(0, 99) < 35);
      step({wb, h7}, l8, rd);
    end

    // reset mid-operation
    step(8'h00, 8'h00, rd);
    step(8'hFF, 8'h5A, rd);
    step(8'h80, 8'h01, rd);
    chk("pre_rst_gpio", gpio_out, 8'h5A);
    chk("pre_rst_perr", {7'b0, proto_err}, 8'h01);
    bus_hi = 8'h7F;
    bus_lo = 8'h02;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_gpio", gpio_out, 8'h00);
    chk("async_rst_perr", {7'b0, proto_err}, 8'h00);
    chk("async_rst_strobe", {7'b0, wr_strobe}, 8'h00);
    chk("async_rst_tick", data_to_cpu, 8'h00);
    model_reset();
    bus_hi = 8'hFF;
    bus_lo = 8'h77;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_edge_write_gpio", gpio_out, 8'h00);
    step(8'h7F, 8'h00, rd);
    chk("rst_edge_write_read", rd, 8'h00);
    step(8'h7F, 8'h02, rd);
    step(8'h00, 8'h00, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
